json_stream_checker: RTL and testbench

Hardware streaming JSON syntax checker. It accepts one document as a byte stream over a valid/ready interface and reports OK, or the first error as an error kind plus a zero-based byte position. It extends the string-level load/expect-error checking flow to an RTL block that sits behind a DMA or UART byte source. It is generalised in nesting depth and position width.

---
 rtl/json_stream_checker_if.sv | 23 ++
 rtl/json_stream_checker.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_json_stream_checker.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/json_stream_checker_if.sv
// Byte-stream handshake carrying one JSON document into the checker.
interface json_stream_checker_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;

  // Byte source side
  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  // Checker side
  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/json_stream_checker.sv
// Streaming JSON syntax checker: consumes one document byte by byte and
// reports OK or the first error kind with its zero-based byte position.
module json_stream_checker #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned POS_W   = 32,
  parameter int unsigned DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  json_stream_checker_if.slave   bus,
  input  logic                   clear,
  output logic                   done,
  output logic                   ok,
  output logic [3:0]             err_kind,
  output logic [POS_W-1:0]       err_pos,
  output logic [DEPTH_W-1:0]     cur_depth
);

  localparam logic [3:0] E_NONE      = 4'd0;
  localparam logic [3:0] E_EOF       = 4'd1;
  localparam logic [3:0] E_VALUE     = 4'd2;
  localparam logic [3:0] E_KEY       = 4'd3;
  localparam logic [3:0] E_COLON     = 4'd4;
  localparam logic [3:0] E_COMMA     = 4'd5;
  localparam logic [3:0] E_MISMATCH  = 4'd6;
  localparam logic [3:0] E_TRAILING  = 4'd7;
  localparam logic [3:0] E_CHAR      = 4'd8;
  localparam logic [3:0] E_ESCAPE    = 4'd9;
  localparam logic [3:0] E_NUMBER    = 4'd10;
  localparam logic [3:0] E_LITERAL   = 4'd11;
  localparam logic [3:0] E_DEPTH     = 4'd12;

  typedef enum logic [4:0] {
    ST_EXP_VALUE,
    ST_OBJ_KEY,
    ST_OBJ_COLON,
    ST_AFTER_VALUE,
    ST_STR,
    ST_STR_ESC,
    ST_STR_HEX,
    ST_NUM_SIGN,
    ST_NUM_ZERO,
    ST_NUM_INT,
    ST_NUM_DOT,
    ST_NUM_FRAC,
    ST_NUM_EXP,
    ST_NUM_EXP_SIGN,
    ST_NUM_EXP_DIG,
    ST_LITERAL,
    ST_DONE
  } state_t;

  state_t             state;
  logic [DEPTH-1:0]   stack;       // one bit per level: 1 = object, 0 = array
  logic [POS_W-1:0]   pos;
  logic               ready_q;
  logic               is_key;      // current string is an object key
  logic               empty_ok;    // container just opened, close allowed
  logic [3:0]         lit_idx;
  logic [1:0]         hex_cnt;

  logic [7:0]         b;
  logic               xfer;
  logic               is_ws, is_digit, is_d19, is_hex, is_exp;
  logic               top_obj;
  logic [POS_W-1:0]   pos_inc;

  state_t             av_st;
  logic [3:0]         av_err;
  logic               av_pop;

  state_t             st_nx;
  logic [3:0]         err_nx;
  logic               push, push_obj, pop;
  logic               key_nx, empty_nx;
  logic [3:0]         lit_nx;
  logic [1:0]         hex_nx;
  logic [DEPTH_W-1:0] depth_nx;
  logic               eof_ok;

  assign bus.s_ready = ready_q;
  assign b           = bus.s_data;
  assign xfer        = bus.s_valid & ready_q;
  assign pos_inc     = (&pos) ? pos : pos + POS_W'(1);

  assign is_ws    = (b == 8'h20) || (b == 8'h09) || (b == 8'h0A) || (b == 8'h0D);
  assign is_digit = (b >= "0") && (b <= "9");
  assign is_d19   = (b >= "1") && (b <= "9");
  assign is_hex   = is_digit || ((b >= "a") && (b <= "f")) || ((b >= "A") && (b <= "F"));
  assign is_exp   = (b == "e") || (b == "E");

  // Remaining characters of true/false/null packed into one small ROM.
  function automatic logic [7:0] lit_char(input logic [3:0] idx);
    case (idx)
      4'd0:    lit_char = "r";
      4'd1:    lit_char = "u";
      4'd2:    lit_char = "e";
      4'd3:    lit_char = "a";
      4'd4:    lit_char = "l";
      4'd5:    lit_char = "s";
      4'd6:    lit_char = "e";
      4'd7:    lit_char = "u";
      4'd8:    lit_char = "l";
      4'd9:    lit_char = "l";
      default: lit_char = 8'h00;
    endcase
  endfunction

  // Top-of-stack container type for the current depth.
  always_comb begin
    top_obj = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (cur_depth == DEPTH_W'(i + 1)) top_obj = stack[i];
    end
  end

  // Byte interpreted in AFTER_VALUE context (also used by number termination).
  always_comb begin
    av_st  = ST_AFTER_VALUE;
    av_err = E_NONE;
    av_pop = 1'b0;
    if (is_ws) begin
      av_st = ST_AFTER_VALUE;
    end else if (cur_depth == '0) begin
      av_err = E_TRAILING;
    end else if (b == ",") begin
      av_st = top_obj ? ST_OBJ_KEY : ST_EXP_VALUE;
    end else if ((b == "]") || (b == "}")) begin
      if ((b == "}") == top_obj) av_pop = 1'b1;
      else                       av_err = E_MISMATCH;
    end else begin
      av_err = E_COMMA;
    end
  end

  // Next-state decode for the byte currently offered.
  always_comb begin
    st_nx    = state;
    err_nx   = E_NONE;
    push     = 1'b0;
    push_obj = 1'b0;
    pop      = 1'b0;
    key_nx   = is_key;
    empty_nx = empty_ok;
    lit_nx   = lit_idx;
    hex_nx   = hex_cnt;
    case (state)
      ST_EXP_VALUE: begin
        if (!is_ws) begin
          empty_nx = 1'b0;
          if ((b == "{") || (b == "[")) begin
            if (cur_depth == DEPTH_W'(DEPTH)) begin
              err_nx = E_DEPTH;
            end else begin
              push     = 1'b1;
              push_obj = (b == "{");
              empty_nx = 1'b1;
              st_nx    = (b == "{") ? ST_OBJ_KEY : ST_EXP_VALUE;
            end
          end else if (b == 8'h22) begin
            key_nx = 1'b0;
            st_nx  = ST_STR;
          end else if (b == "-") begin
            st_nx = ST_NUM_SIGN;
          end else if (b == "0") begin
            st_nx = ST_NUM_ZERO;
          end else if (is_d19) begin
            st_nx = ST_NUM_INT;
          end else if (b == "t") begin
            lit_nx = 4'd0;
            st_nx  = ST_LITERAL;
          end else if (b == "f") begin
            lit_nx = 4'd3;
            st_nx  = ST_LITERAL;
          end else if (b == "n") begin
            lit_nx = 4'd7;
            st_nx  = ST_LITERAL;
          end else if ((b == "]") && empty_ok) begin
            pop   = 1'b1;
            st_nx = ST_AFTER_VALUE;
          end else begin
            err_nx = E_VALUE;
          end
        end
      end
      ST_OBJ_KEY: begin
        if (!is_ws) begin
          empty_nx = 1'b0;
          if (b == 8'h22) begin
            key_nx = 1'b1;
            st_nx  = ST_STR;
          end else if ((b == "}") && empty_ok) begin
            pop   = 1'b1;
            st_nx = ST_AFTER_VALUE;
          end else begin
            err_nx = E_KEY;
          end
        end
      end
      ST_OBJ_COLON: begin
        if (!is_ws) begin
          if (b == ":") st_nx  = ST_EXP_VALUE;
          else          err_nx = E_COLON;
        end
      end
      ST_AFTER_VALUE: begin
        st_nx  = av_st;
        err_nx = av_err;
        pop    = av_pop;
      end
      ST_STR: begin
        if (b == 8'h22)      st_nx  = is_key ? ST_OBJ_COLON : ST_AFTER_VALUE;
        else if (b == 8'h5C) st_nx  = ST_STR_ESC;
        else if (b < 8'h20)  err_nx = E_CHAR;
      end
      ST_STR_ESC: begin
        if ((b == 8'h22) || (b == 8'h5C) || (b == "/") || (b == "b") ||
            (b == "f") || (b == "n") || (b == "r") || (b == "t")) begin
          st_nx = ST_STR;
        end else if (b == "u") begin
          hex_nx = 2'd0;
          st_nx  = ST_STR_HEX;
        end else begin
          err_nx = E_ESCAPE;
        end
      end
      ST_STR_HEX: begin
        if (!is_hex)              err_nx = E_ESCAPE;
        else if (hex_cnt == 2'd3) st_nx  = ST_STR;
        else                      hex_nx = hex_cnt + 2'd1;
      end
      ST_NUM_SIGN: begin
        if (b == "0")  st_nx  = ST_NUM_ZERO;
        else if (is_d19) st_nx = ST_NUM_INT;
        else           err_nx = E_NUMBER;
      end
      ST_NUM_ZERO, ST_NUM_INT: begin
        if (is_digit && (state == ST_NUM_INT)) st_nx = ST_NUM_INT;
        else if (b == ".")                     st_nx = ST_NUM_DOT;
        else if (is_exp)                       st_nx = ST_NUM_EXP;
        else begin
          st_nx  = av_st;
          err_nx = av_err;
          pop    = av_pop;
        end
      end
      ST_NUM_DOT: begin
        if (is_digit) st_nx  = ST_NUM_FRAC;
        else          err_nx = E_NUMBER;
      end
      ST_NUM_FRAC: begin
        if (is_digit)    st_nx = ST_NUM_FRAC;
        else if (is_exp) st_nx = ST_NUM_EXP;
        else begin
          st_nx  = av_st;
          err_nx = av_err;
          pop    = av_pop;
        end
      end
      ST_NUM_EXP: begin
        if ((b == "+") || (b == "-")) st_nx  = ST_NUM_EXP_SIGN;
        else if (is_digit)            st_nx  = ST_NUM_EXP_DIG;
        else                          err_nx = E_NUMBER;
      end
      ST_NUM_EXP_SIGN: begin
        if (is_digit) st_nx  = ST_NUM_EXP_DIG;
        else          err_nx = E_NUMBER;
      end
      ST_NUM_EXP_DIG: begin
        if (!is_digit) begin
          st_nx  = av_st;
          err_nx = av_err;
          pop    = av_pop;
        end
      end
      ST_LITERAL: begin
        if (b != lit_char(lit_idx))                                 err_nx = E_LITERAL;
        else if ((lit_idx == 4'd2) || (lit_idx == 4'd6) || (lit_idx == 4'd9)) st_nx = ST_AFTER_VALUE;
        else                                                        lit_nx = lit_idx + 4'd1;
      end
      default: st_nx = state;
    endcase
  end

  // End-of-document acceptance after the current byte is applied.
  always_comb begin
    if (push)     depth_nx = cur_depth + DEPTH_W'(1);
    else if (pop) depth_nx = cur_depth - DEPTH_W'(1);
    else          depth_nx = cur_depth;
    eof_ok = (depth_nx == '0) &&
             ((st_nx == ST_AFTER_VALUE) || (st_nx == ST_NUM_ZERO) ||
              (st_nx == ST_NUM_INT) || (st_nx == ST_NUM_FRAC) ||
              (st_nx == ST_NUM_EXP_DIG));
  end

  // State, stack, position and registered result.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state     <= ST_EXP_VALUE;
      stack     <= '0;
      pos       <= '0;
      ready_q   <= 1'b1;
      is_key    <= 1'b0;
      empty_ok  <= 1'b0;
      lit_idx   <= 4'd0;
      hex_cnt   <= 2'd0;
      done      <= 1'b0;
      ok        <= 1'b0;
      err_kind  <= E_NONE;
      err_pos   <= '0;
      cur_depth <= '0;
    end else if (xfer) begin
      pos <= pos_inc;
      if (err_nx != E_NONE) begin
        state    <= ST_DONE;
        ready_q  <= 1'b0;
        done     <= 1'b1;
        ok       <= 1'b0;
        err_kind <= err_nx;
        err_pos  <= pos;
      end else begin
        state     <= st_nx;
        is_key    <= key_nx;
        empty_ok  <= empty_nx;
        lit_idx   <= lit_nx;
        hex_cnt   <= hex_nx;
        cur_depth <= depth_nx;
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (push && (cur_depth == DEPTH_W'(i))) stack[i] <= push_obj;
        end
        if (bus.s_last) begin
          state   <= ST_DONE;
          ready_q <= 1'b0;
          done    <= 1'b1;
          if (eof_ok) begin
            ok <= 1'b1;
          end else begin
            err_kind <= E_EOF;
            err_pos  <= pos_inc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_json_stream_checker.sv
// Directed bench for json_stream_checker (DEPTH=4 so overflow is reachable).
module tb_json_stream_checker;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        done;
  logic        ok;
  logic [3:0]  err_kind;
  logic [31:0] err_pos;
  logic [2:0]  cur_depth;

  int n_tests = 0;
  int n_fail  = 0;

  json_stream_checker_if bus ();

  json_stream_checker #(.DEPTH(4), .POS_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .clear     (clear),
    .done      (done),
    .ok        (ok),
    .err_kind  (err_kind),
    .err_pos   (err_pos),
    .cur_depth (cur_depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Offer a document byte by byte at negedges; stop once the checker refuses.
  task automatic send_doc(input string s, input bit with_last, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps) begin
        bus.s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      if (bus.s_ready !== 1'b1) break;
      bus.s_valid = 1'b1;
      bus.s_data  = s[i];
      bus.s_last  = with_last && (i == s.len() - 1);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: done=%b required 1 (timeout)", name, done);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.s_ready); end
    n_tests++;
    if (done !== 1'b0 || ok !== 1'b0) begin n_fail++; $display("FAIL reset_done_ok: got %b%b want 00", done, ok); end
    n_tests++;
    if (err_kind !== 4'd0 || err_pos !== 32'd0 || cur_depth !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_err: kind=%0d pos=%0d depth=%0d want 0 0 0", err_kind, err_pos, cur_depth);
    end
  endtask

  task automatic test_valid_doc();
    send_doc("{\"a\":[1,-2.5e+3,true,null],\"b\":\"x\\u00e9\"}", 1'b1, 1'b1);
    wait_done("valid_doc_done");
    n_tests++;
    if (ok !== 1'b1 || err_kind !== 4'd0) begin n_fail++; $display("FAIL valid_doc: ok=%b kind=%0d want 1 0", ok, err_kind); end
    n_tests++;
    if (cur_depth !== 3'd0) begin n_fail++; $display("FAIL valid_doc_depth: got %0d want 0", cur_depth); end
    n_tests++;
    if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL valid_doc_ready: got %b want 0", bus.s_ready); end
  endtask

  task automatic test_eof();
    pulse_clear();
    send_doc("[1,2", 1'b1, 1'b0);
    wait_done("eof_done");
    n_tests++;
    if (ok !== 1'b0 || err_kind !== 4'd1 || err_pos !== 32'd4) begin
      n_fail++; $display("FAIL eof_array: ok=%b kind=%0d pos=%0d want 0 1 4", ok, err_kind, err_pos);
    end
    pulse_clear();
    send_doc("tru", 1'b1, 1'b0);
    wait_done("eof_lit_done");
    n_tests++;
    if (err_kind !== 4'd1 || err_pos !== 32'd3) begin
      n_fail++; $display("FAIL eof_literal: kind=%0d pos=%0d want 1 3", err_kind, err_pos);
    end
  endtask

  task automatic test_colon();
    pulse_clear();
    send_doc("{\"a\" 1}", 1'b1, 1'b0);
    wait_done("colon_done");
    n_tests++;
    if (err_kind !== 4'd4 || err_pos !== 32'd5) begin
      n_fail++; $display("FAIL colon: kind=%0d pos=%0d want 4 5", err_kind, err_pos);
    end
    n_tests++;
    if (bus.s_ready !== 1'b0 || ok !== 1'b0) begin
      n_fail++; $display("FAIL colon_ready: ready=%b ok=%b want 0 0", bus.s_ready, ok);
    end
  endtask

  task automatic test_mismatch();
    pulse_clear();
    send_doc("[1}", 1'b1, 1'b0);
    wait_done("mismatch_done");
    n_tests++;
    if (err_kind !== 4'd6 || err_pos !== 32'd2) begin
      n_fail++; $display("FAIL mismatch: kind=%0d pos=%0d want 6 2", err_kind, err_pos);
    end
  endtask

  task automatic test_trailing();
    pulse_clear();
    send_doc("01", 1'b1, 1'b0);
    wait_done("trailing_done");
    n_tests++;
    if (err_kind !== 4'd7 || err_pos !== 32'd1) begin
      n_fail++; $display("FAIL trailing: kind=%0d pos=%0d want 7 1", err_kind, err_pos);
    end
  endtask

  task automatic test_string_errors();
    string s;
    pulse_clear();
    send_doc("\"\\q\"", 1'b1, 1'b0);
    wait_done("escape_done");
    n_tests++;
    if (err_kind !== 4'd9 || err_pos !== 32'd2) begin
      n_fail++; $display("FAIL escape: kind=%0d pos=%0d want 9 2", err_kind, err_pos);
    end
    pulse_clear();
    s = "\"aX\"";
    s.putc(2, 8'h01);
    send_doc(s, 1'b1, 1'b0);
    wait_done("ctrl_done");
    n_tests++;
    if (err_kind !== 4'd8 || err_pos !== 32'd2) begin
      n_fail++; $display("FAIL ctrl_char: kind=%0d pos=%0d want 8 2", err_kind, err_pos);
    end
  endtask

  task automatic test_depth();
    pulse_clear();
    send_doc("[[[[[", 1'b1, 1'b0);
    wait_done("depth_done");
    n_tests++;
    if (err_kind !== 4'd12 || err_pos !== 32'd4 || cur_depth !== 3'd4) begin
      n_fail++; $display("FAIL depth_overflow: kind=%0d pos=%0d depth=%0d want 12 4 4", err_kind, err_pos, cur_depth);
    end
    pulse_clear();
    send_doc("[[[[]]]]", 1'b1, 1'b1);
    wait_done("depth_max_done");
    n_tests++;
    if (ok !== 1'b1 || err_kind !== 4'd0 || cur_depth !== 3'd0) begin
      n_fail++; $display("FAIL depth_max: ok=%b kind=%0d depth=%0d want 1 0 0", ok, err_kind, cur_depth);
    end
    pulse_clear();
    send_doc(" { } ", 1'b1, 1'b0);
    wait_done("empty_obj_done");
    n_tests++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL empty_obj: ok=%b kind=%0d want ok 1", ok, err_kind); end
  endtask

  task automatic test_clear_recover();
    pulse_clear();
    send_doc("[x", 1'b1, 1'b0);
    wait_done("recover_err_done");
    n_tests++;
    if (err_kind !== 4'd2 || err_pos !== 32'd1 || bus.s_ready !== 1'b0) begin
      n_fail++; $display("FAIL recover_err: kind=%0d pos=%0d ready=%b want 2 1 0", err_kind, err_pos, bus.s_ready);
    end
    pulse_clear();
    n_tests++;
    if (done !== 1'b0 || bus.s_ready !== 1'b1 || err_kind !== 4'd0) begin
      n_fail++; $display("FAIL after_clear: done=%b ready=%b kind=%0d want 0 1 0", done, bus.s_ready, err_kind);
    end
    send_doc("42", 1'b1, 1'b0);
    wait_done("recover_done");
    n_tests++;
    if (ok !== 1'b1 || err_kind !== 4'd0) begin
      n_fail++; $display("FAIL recover_42: ok=%b kind=%0d want 1 0", ok, err_kind);
    end
  endtask

  task automatic test_reset_mid();
    pulse_clear();
    send_doc("[[1,", 1'b0, 1'b0);
    n_tests++;
    if (cur_depth !== 3'd2 || done !== 1'b0) begin
      n_fail++; $display("FAIL mid_doc: depth=%0d done=%b want 2 0", cur_depth, done);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (cur_depth !== 3'd0 || done !== 1'b0 || ok !== 1'b0 || bus.s_ready !== 1'b1 ||
        err_kind !== 4'd0 || err_pos !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset: depth=%0d done=%b ok=%b ready=%b kind=%0d pos=%0d want 0 0 0 1 0 0",
               cur_depth, done, ok, bus.s_ready, err_kind, err_pos);
    end
    send_doc("[1", 1'b1, 1'b0);
    wait_done("post_reset_done");
    n_tests++;
    if (err_kind !== 4'd1 || err_pos !== 32'd2) begin
      n_fail++; $display("FAIL post_reset_pos: kind=%0d pos=%0d want 1 2", err_kind, err_pos);
    end
  endtask

  initial begin
    rst         = 1'b1;
    clear       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_valid_doc();
    test_eof();
    test_colon();
    test_mismatch();
    test_trailing();
    test_string_errors();
    test_depth();
    test_clear_recover();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
